// File: rtl/ysyx_25040111_burst_responder.sv
// Burst responder: serves cache-refill reads of chlen+1 words from a
// single-outstanding word memory port, one word per chready pulse.
//
// Ports:
//   clock, reset               clock; synchronous active-low reset
//   chvalid/chaddr/chlen/chburst  refill request from the initiator
//   chready/chdata             one-cycle beat strobe and beat data
//   err                        sticky error level (cleared by reset only)
//   mem_ren/mem_raddr          one-cycle read strobe and word address
//   mem_rvalid/mem_rdata       read response
//   stat_txn/stat_beat         completed transactions / delivered beats
//
// Optional feature macro: BURST_RESP_STATS_EN builds the statistic
// counters; without it stat_txn and stat_beat are tied to zero.

module ysyx_25040111_burst_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          SIZE_LOG2 = 16,
    parameter int          MAX_LEN   = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        chvalid,
    input  logic [31:0] chaddr,
    input  logic [7:0]  chlen,
    input  logic        chburst,
    output logic        chready,
    output logic [31:0] chdata,
    output logic        err,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] stat_txn,
    output logic [31:0] stat_beat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_BEAT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [32:0] W_LO   = {1'b0, BASE_ADDR};
    localparam logic [32:0] W_SIZE = 33'd1 << SIZE_LOG2;
    localparam logic [7:0]  W_MAX  = 8'(MAX_LEN);

    // Sums are 33 bits wide so a carry past 2**32 lands in bit 32
    // and is rejected rather than aliasing back into the window.
    function automatic logic in_window(input logic [32:0] a);
        logic [32:0] off;
        off = a - W_LO;
        return !a[32] && (a >= W_LO) && (off < W_SIZE);
    endfunction

    state_t      r_state;
    logic [7:0]  r_len;
    logic        r_burst;
    logic [31:0] r_base;
    logic [7:0]  r_beat;
    logic [31:0] r_chdata;
    logic [31:0] r_raddr;
    logic        r_abort;

    state_t      w_state_n;
    logic [7:0]  w_len_n;
    logic        w_burst_n;
    logic [31:0] w_base_n;
    logic [7:0]  w_beat_n;
    logic [31:0] w_chdata_n;
    logic [31:0] w_raddr_n;
    logic        w_abort_n;
    logic        w_ren;
    logic        w_chready;

    logic [32:0] w_sum;
    logic        w_issue_ok;
    logic        w_req_ok;

    // Non-burst beats use the live chaddr: the initiator advanced it
    // at the previous chready edge.
    assign w_sum = r_burst
                 ? ({1'b0, r_base} + {23'b0, r_beat, 2'b00})
                 : {1'b0, chaddr};

    assign w_issue_ok = in_window(w_sum) && (w_sum[1:0] == 2'b00);

    assign w_req_ok = (chaddr[1:0] == 2'b00)
                   && (chlen <= W_MAX)
                   && in_window({1'b0, chaddr});

    always_comb begin
        w_state_n  = r_state;
        w_len_n    = r_len;
        w_burst_n  = r_burst;
        w_base_n   = r_base;
        w_beat_n   = r_beat;
        w_chdata_n = r_chdata;
        w_raddr_n  = r_raddr;
        w_abort_n  = r_abort;
        w_ren      = 1'b0;
        w_chready  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_abort_n = 1'b0;
                if (chvalid) begin
                    w_len_n   = chlen;
                    w_burst_n = chburst;
                    w_base_n  = chaddr;
                    w_beat_n  = 8'd0;
                    w_state_n = w_req_ok ? S_ISSUE : S_FAIL;
                end
            end
            S_ISSUE: begin
                if (!chvalid) begin
                    w_beat_n  = 8'd0;
                    w_state_n = S_IDLE;
                end else if (!w_issue_ok) begin
                    w_state_n = S_FAIL;
                end else begin
                    w_ren     = 1'b1;
                    w_raddr_n = w_sum[31:0];
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                // A drop while the read is outstanding is remembered so
                // the returning word is discarded even if chvalid rises again.
                if (!chvalid) begin
                    w_abort_n = 1'b1;
                end
                if (mem_rvalid) begin
                    if (r_abort || !chvalid) begin
                        w_beat_n  = 8'd0;
                        w_abort_n = 1'b0;
                        w_state_n = S_IDLE;
                    end else begin
                        w_chdata_n = mem_rdata;
                        w_state_n  = S_BEAT;
                    end
                end
            end
            S_BEAT: begin
                if (!chvalid) begin
                    w_beat_n  = 8'd0;
                    w_state_n = S_IDLE;
                end else begin
                    w_chready = 1'b1;
                    if (r_beat == r_len) begin
                        w_beat_n  = 8'd0;
                        w_state_n = S_DONE;
                    end else begin
                        w_beat_n  = r_beat + 8'd1;
                        w_state_n = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (!chvalid) begin
                    w_state_n = S_IDLE;
                end
            end
            S_FAIL: begin
                w_state_n = S_FAIL;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_len    <= 8'd0;
            r_burst  <= 1'b0;
            r_base   <= 32'd0;
            r_beat   <= 8'd0;
            r_chdata <= 32'd0;
            r_raddr  <= 32'd0;
            r_abort  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_len    <= w_len_n;
            r_burst  <= w_burst_n;
            r_base   <= w_base_n;
            r_beat   <= w_beat_n;
            r_chdata <= w_chdata_n;
            r_raddr  <= w_raddr_n;
            r_abort  <= w_abort_n;
        end
    end

    assign chready   = w_chready;
    assign chdata    = r_chdata;
    assign err       = (r_state == S_FAIL);
    assign mem_ren   = w_ren;
    assign mem_raddr = w_ren ? w_sum[31:0] : r_raddr;

`ifdef BURST_RESP_STATS_EN
    logic [31:0] r_stat_txn;
    logic [31:0] r_stat_beat;
    logic        w_txn_done;

    assign w_txn_done = (r_state == S_BEAT) && chvalid
                     && (r_beat == r_len);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stat_txn  <= 32'd0;
            r_stat_beat <= 32'd0;
        end else begin
            if (w_txn_done) begin
                r_stat_txn <= r_stat_txn + 32'd1;
            end
            if (w_chready) begin
                r_stat_beat <= r_stat_beat + 32'd1;
            end
        end
    end

    assign stat_txn  = r_stat_txn;
    assign stat_beat = r_stat_beat;
`else
    assign stat_txn  = 32'd0;
    assign stat_beat = 32'd0;
`endif

endmodule
